// File: rtl/sc_playershiftreg_pkg.sv
// -----------------------------------------------------------------------------
// sc_playershiftreg_pkg
// Shared definitions for the player position datapath and the player state
// machine that drives it. Both import this package so that the shift-selection
// encoding exists in exactly one place.
//
// Contents:
//   SEL_HOLD / SEL_LEFT / SEL_RIGHT / SEL_LOAD : 2-bit shift-selection codes
//   sel_t                                      : type of a shift-selection value
//   SEL_WIDTH                                  : width of a shift-selection value
// -----------------------------------------------------------------------------
package sc_playershiftreg_pkg;

    localparam int SEL_WIDTH = 2;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    // Hold is all-ones so that an idle machine driving its outputs high leaves
    // the position alone. Load is all-zeros.
    localparam sel_t SEL_HOLD  = 2'b11;
    localparam sel_t SEL_LEFT  = 2'b01;
    localparam sel_t SEL_RIGHT = 2'b10;
    localparam sel_t SEL_LOAD  = 2'b00;

endpackage : sc_playershiftreg_pkg

// File: rtl/sc_onehot_encoder.sv
// -----------------------------------------------------------------------------
// sc_onehot_encoder
// Purely combinational one-hot to binary encoder with a validity flag.
//
// Parameters:
//   WIDTH     : width of the one-hot input (>= 2)
// Ports:
//   data      in  WIDTH          : value to encode
//   index     out $clog2(WIDTH)  : bit position of the single set bit, or 0
//                                  when data is not one-hot
//   is_onehot out 1              : 1 when exactly one bit of data is set
// -----------------------------------------------------------------------------
module sc_onehot_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     is_onehot
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] index_acc;

    // A value is one-hot when it is non-zero and clearing its lowest set bit
    // leaves nothing behind.
    assign is_onehot = (data != '0) && ((data & (data - 1'b1)) == '0);

    // OR together the positions of every set bit. For a one-hot input this is
    // exactly the position of the set bit; for anything else the result is
    // meaningless, so the output is forced to zero in that case.
    always_comb begin
        index_acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                index_acc = index_acc | IDX_W'(i);
            end
        end
    end

    assign index = is_onehot ? index_acc : '0;

endmodule : sc_onehot_encoder

// File: rtl/sc_player_shiftregister.sv
// -----------------------------------------------------------------------------
// sc_player_shiftregister
// Player position datapath. Holds a one-hot position register and applies the
// clear / shift / load commands issued by the player state machine. Feeds back
// active-low edge flags so the machine can gate moves, and exports the binary
// position and a saturating count of accepted shifts.
//
// Configuration macro:
//   SC_PLAYERSHIFTREG_WRAP_EN : when defined, shifts past either edge wrap
//                               around (and count), and both edge flags are
//                               tied high. When undefined, edge shifts are
//                               refused and the edge flags are live.
//
// Parameters:
//   WIDTH     : position register width (>= 2)
//   INIT_POS  : one-hot value loaded on reset and on clear
//   CNT_WIDTH : move counter width
// Ports:
//   SC_PLAYERSHIFTREG_CLOCK_50                  in  1         : clock
//   SC_PLAYERSHIFTREG_RESET_InHigh              in  1         : sync reset, high
//   SC_PLAYERSHIFTREG_clear_InLow               in  1         : sync clear, low
//   SC_PLAYERSHIFTREG_shiftselection_In         in  2         : command
//   SC_PLAYERSHIFTREG_data_In                   in  WIDTH     : load value
//   SC_PLAYERSHIFTREG_data_Out                  out WIDTH     : position
//   SC_PLAYERSHIFTREG_index_Out                 out clog2     : position index
//   SC_PLAYERSHIFTREG_izquierdacomparator_OutLow out 1        : 0 at left edge
//   SC_PLAYERSHIFTREG_derechacomparator_OutLow  out 1         : 0 at right edge
//   SC_PLAYERSHIFTREG_moves_Out                 out CNT_WIDTH : accepted shifts
//   SC_PLAYERSHIFTREG_loaderror_Out             out 1         : rejected load
// -----------------------------------------------------------------------------
module sc_player_shiftregister
    import sc_playershiftreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT_POS  = WIDTH'(8'b0001_0000),
    parameter int               CNT_WIDTH = 8
) (
    input  logic                     SC_PLAYERSHIFTREG_CLOCK_50,
    input  logic                     SC_PLAYERSHIFTREG_RESET_InHigh,
    input  logic                     SC_PLAYERSHIFTREG_clear_InLow,
    input  logic [SEL_WIDTH-1:0]     SC_PLAYERSHIFTREG_shiftselection_In,
    input  logic [WIDTH-1:0]         SC_PLAYERSHIFTREG_data_In,
    output logic [WIDTH-1:0]         SC_PLAYERSHIFTREG_data_Out,
    output logic [$clog2(WIDTH)-1:0] SC_PLAYERSHIFTREG_index_Out,
    output logic                     SC_PLAYERSHIFTREG_izquierdacomparator_OutLow,
    output logic                     SC_PLAYERSHIFTREG_derechacomparator_OutLow,
    output logic [CNT_WIDTH-1:0]     SC_PLAYERSHIFTREG_moves_Out,
    output logic                     SC_PLAYERSHIFTREG_loaderror_Out
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0]     pos;
    logic [WIDTH-1:0]     pos_next;
    logic [CNT_WIDTH-1:0] moves;
    logic                 loaderror;
    logic                 shift_taken;
    logic                 load_rejected;
    logic                 data_onehot;
    logic [IDX_W-1:0]     pos_index;
    logic [IDX_W-1:0]     data_index_unused;
    logic                 pos_onehot_unused;

    // Decode of the live position register drives the index output.
    sc_onehot_encoder #(
        .WIDTH (WIDTH)
    ) u_pos_encoder (
        .data      (pos),
        .index     (pos_index),
        .is_onehot (pos_onehot_unused)
    );

    // A second encoder screens the parallel-load value; only its one-hot flag
    // matters here.
    sc_onehot_encoder #(
        .WIDTH (WIDTH)
    ) u_load_encoder (
        .data      (SC_PLAYERSHIFTREG_data_In),
        .index     (data_index_unused),
        .is_onehot (data_onehot)
    );

    // Work out where the position would go under the current command, and
    // whether that counts as an accepted shift or a rejected load. Shifts that
    // would push the bit off an edge are refused here even though the machine
    // is expected to gate them, so the register can never become empty.
    always_comb begin
        pos_next      = pos;
        shift_taken   = 1'b0;
        load_rejected = 1'b0;
        case (SC_PLAYERSHIFTREG_shiftselection_In)
            SEL_LEFT: begin
`ifdef SC_PLAYERSHIFTREG_WRAP_EN
                pos_next    = {pos[WIDTH-2:0], pos[WIDTH-1]};
                shift_taken = 1'b1;
`else
                if (!pos[WIDTH-1]) begin
                    pos_next    = pos << 1;
                    shift_taken = 1'b1;
                end
`endif
            end
            SEL_RIGHT: begin
`ifdef SC_PLAYERSHIFTREG_WRAP_EN
                pos_next    = {pos[0], pos[WIDTH-1:1]};
                shift_taken = 1'b1;
`else
                if (!pos[0]) begin
                    pos_next    = pos >> 1;
                    shift_taken = 1'b1;
                end
`endif
            end
            SEL_LOAD: begin
                if (data_onehot) begin
                    pos_next = SC_PLAYERSHIFTREG_data_In;
                end else begin
                    load_rejected = 1'b1;
                end
            end
            default: begin
                pos_next = pos;
            end
        endcase
    end

    // State update. Reset and clear both return to the start position with a
    // zeroed counter and discard whatever command was presented. The counter
    // sticks at all-ones rather than rolling over, and the load error flag is
    // rewritten every cycle so it only ever lasts one cycle.
    always_ff @(posedge SC_PLAYERSHIFTREG_CLOCK_50) begin
        if (SC_PLAYERSHIFTREG_RESET_InHigh) begin
            pos       <= INIT_POS;
            moves     <= '0;
            loaderror <= 1'b0;
        end else if (!SC_PLAYERSHIFTREG_clear_InLow) begin
            pos       <= INIT_POS;
            moves     <= '0;
            loaderror <= 1'b0;
        end else begin
            pos       <= pos_next;
            loaderror <= load_rejected;
            if (shift_taken && (moves != '1)) begin
                moves <= moves + 1'b1;
            end
        end
    end

    assign SC_PLAYERSHIFTREG_data_Out      = pos;
    assign SC_PLAYERSHIFTREG_index_Out     = pos_index;
    assign SC_PLAYERSHIFTREG_moves_Out     = moves;
    assign SC_PLAYERSHIFTREG_loaderror_Out = loaderror;

    // Edge flags decode only the register. With wrapping enabled there is no
    // edge for the machine to respect, so both stay high.
`ifdef SC_PLAYERSHIFTREG_WRAP_EN
    assign SC_PLAYERSHIFTREG_izquierdacomparator_OutLow = 1'b1;
    assign SC_PLAYERSHIFTREG_derechacomparator_OutLow   = 1'b1;
`else
    assign SC_PLAYERSHIFTREG_izquierdacomparator_OutLow = ~pos[WIDTH-1];
    assign SC_PLAYERSHIFTREG_derechacomparator_OutLow   = ~pos[0];
`endif

endmodule : sc_player_shiftregister

// File: doc/sc_player_shiftregister.md
# sc_player_shiftregister

Player-position datapath driven by the player state machine. Holds a one-hot WIDTH-bit position register and applies the machine's clear and shift-selection commands to it. Feeds back active-low left and right edge flags that the machine uses to gate moves. Also exports the binary position index and a saturating move counter to the display/scoring logic.

## Interface
Parameters:
- WIDTH, 8: position register width; must be at least 2.
- INIT_POS, 8'b0001_0000: one-hot value loaded on reset and on clear.
- CNT_WIDTH, 8: width of the move counter.

Ports:
- SC_PLAYERSHIFTREG_CLOCK_50 in 1: the only clock; everything updates on the rising edge.
- SC_PLAYERSHIFTREG_RESET_InHigh in 1: reset, synchronous and active-high.
- SC_PLAYERSHIFTREG_clear_InLow in 1: synchronous clear to INIT_POS; active low.
- SC_PLAYERSHIFTREG_shiftselection_In in 2: command. 11 = hold, 01 = shift left, 10 = shift right, 00 = parallel load.
- SC_PLAYERSHIFTREG_data_In in WIDTH: parallel-load value.
- SC_PLAYERSHIFTREG_data_Out out WIDTH: position register.
- SC_PLAYERSHIFTREG_index_Out out $clog2(WIDTH): bit index of the set bit.
- SC_PLAYERSHIFTREG_izquierdacomparator_OutLow out 1: 0 when the MSB is set (left edge).
- SC_PLAYERSHIFTREG_derechacomparator_OutLow out 1: 0 when the LSB is set (right edge).
- SC_PLAYERSHIFTREG_moves_Out out CNT_WIDTH: count of accepted shifts.
- SC_PLAYERSHIFTREG_loaderror_Out out 1: one-cycle pulse when a load is rejected.

## Operation
Command priority each cycle, highest first:
1. Reset: register = INIT_POS, moves = 0, loaderror = 0.
2. Clear (clear_InLow = 0): register = INIT_POS, moves = 0. The shift-selection value is ignored.
3. Shift-selection command:
   - 11: hold the register.
   - 01: register << 1 (toward MSB). Accepted only if MSB = 0.
   - 10: register >> 1 (toward LSB). Accepted only if LSB = 0.
   - 00: register = data_In, only if data_In has exactly one bit set. Otherwise the register holds and loaderror pulses for one cycle.

Rejected commands:
- A shift refused at an edge leaves the register and the move counter unchanged. This protects the register even if the machine does not gate the move.
- A rejected load does not change the move counter.

Move counter:
- Increments by 1 on every accepted shift.
- Saturates at 2^CNT_WIDTH-1.
- Loads do not count.

Outputs:
- The two comparator outputs and index_Out are combinational decodes of the register only. They do not depend on the inputs in the same cycle.
- index_Out = 0 if the register is ever non-one-hot. This is unreachable by design.

## Timing
- All state updates on the rising clock edge.
- A command sampled at edge N is visible on data_Out, index_Out and the comparator outputs after edge N; the machine sees the new edge flags in its next state.
- Move counter: updates on the same edge as the shift.
- loaderror: asserted for exactly one cycle, after the edge that sampled the rejected load.
- Values out of reset:
  - data_Out = INIT_POS and moves = 0.
  - index_Out = index of INIT_POS.
  - loaderror = 0.
  - Comparator outputs = 1 unless INIT_POS sits on an edge.
- Reset asserted in the middle of a command sequence: the next edge fully reinitialises the block, and the pending command is discarded.

## Configuration
SC_PLAYERSHIFTREG_WRAP_EN selects edge behaviour.
- Defined:
  - A shift left from the MSB moves the bit to the LSB.
  - A shift right from the LSB moves the bit to the MSB.
  - Both wrapping shifts are accepted and counted.
  - Both comparator outputs are tied to 1.
- Undefined: edge shifts are rejected as described under Operation, and the comparator outputs are live.

## Structure
- Package sc_playershiftreg_pkg holds the shift-selection codes as localparams: SEL_HOLD = 2'b11, SEL_LEFT = 2'b01, SEL_RIGHT = 2'b10, SEL_LOAD = 2'b00.
- The player state machine imports the same package.
- One sub-module, sc_onehot_encoder, parameterised by WIDTH. It outputs the binary index and an is_onehot flag. The flag is reused to validate data_In for loads.

## Test plan
Conditions: WIDTH = 8, INIT_POS = 8'h10, wrap macro undefined.
- Reset held for 2 cycles, then released → data_Out = 8'h10, index = 4, moves = 0, both comparators = 1.
- Shift left 3 times → 8'h80, index = 7, izquierdacomparator = 0, moves = 3. A 4th shift left → still 8'h80, moves = 3.
- From 8'h80, shift right 7 times → 8'h01, derechacomparator = 0, moves = 10.
- Load 8'h24 → register unchanged, loaderror high for exactly 1 cycle. Load 8'h02 → 8'h02, moves unchanged.
- clear_InLow = 0 with shiftselection = 01 in the same cycle → 8'h10, moves = 0.
- With SC_PLAYERSHIFTREG_WRAP_EN defined, shift left from 8'h80 → 8'h01, moves incremented, both comparators = 1.
